// File: rtl/bp_me_mem_port_mux_pkg.sv
// Shared message type and sizing helpers for the memory port concentrator.
// Imported by the mux top and its FIFO sub-module.
package bp_me_mem_port_mux_pkg;

    typedef enum logic [3:0] {
        e_mem_msg_rd    = 4'h0,
        e_mem_msg_wr    = 4'h1,
        e_mem_msg_uc_rd = 4'h2,
        e_mem_msg_uc_wr = 4'h3
    } bp_mem_msg_e;

    typedef struct packed {
        bp_mem_msg_e msg_type;
        logic [27:0] addr;
        logic [31:0] data;
    } bp_cce_mem_msg_s;

    // Never returns zero, so a single-port build still gets a 1-bit id.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_me_mem_port_mux_fifo.sv
// Circular FIFO: ready-valid on the write side, valid-yumi on the read side.
// Async active-low reset also clears the storage, so data outputs read 0 in reset.
module bp_me_mem_mux_fifo
    import bp_me_mem_port_mux_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [width_p-1:0]  mem_d [els_p];
    logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                push, pop;

    assign ready_o = (cnt_q != full_cnt_lp);
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = data_i;
            wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + ptr_w_lp'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + ptr_w_lp'(1);
        end
        cnt_d = cnt_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/bp_me_mem_port_mux.sv
// N-client concentrator onto one memory port: round-robin command arbitration with
// per-port outstanding limits, in-order response routing, sticky orphan-response error.
module bp_me_mem_port_mux
    import bp_me_mem_port_mux_pkg::*;
#(
    parameter int num_ports_p       = 2,
    parameter int msg_width_p       = $bits(bp_cce_mem_msg_s),
    parameter int max_outstanding_p = 4,
    parameter int order_fifo_els_p  = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_ports_p*msg_width_p-1:0] cmd_i,
    input  logic [num_ports_p-1:0]             cmd_v_i,
    output logic [num_ports_p-1:0]             cmd_ready_o,
    output logic [num_ports_p*msg_width_p-1:0] resp_o,
    output logic [num_ports_p-1:0]             resp_v_o,
    input  logic [num_ports_p-1:0]             resp_yumi_i,
    output logic [msg_width_p-1:0]             mem_cmd_o,
    output logic                               mem_cmd_v_o,
    input  logic                               mem_cmd_yumi_i,
    input  logic [msg_width_p-1:0]             mem_resp_i,
    input  logic                               mem_resp_v_i,
    output logic                               mem_resp_ready_o,
    output logic                               error_o
);
    localparam int id_w_lp  = safe_clog2(num_ports_p);
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);
    localparam logic [cnt_w_lp-1:0] max_cnt_lp   = cnt_w_lp'(max_outstanding_p);
    localparam logic [id_w_lp-1:0]  last_port_lp = id_w_lp'(num_ports_p - 1);

    logic [msg_width_p-1:0] cbuf_data [num_ports_p];
    logic [num_ports_p-1:0] cbuf_v, cbuf_ready, cbuf_yumi;
    logic [num_ports_p-1:0] rbuf_ready, rbuf_push;
    logic [num_ports_p-1:0] eligible, cnt_inc, cnt_dec;
    logic [cnt_w_lp-1:0]    cnt_q [num_ports_p];
    logic [cnt_w_lp-1:0]    cnt_d [num_ports_p];

    logic                   order_ready, order_v, order_pop;
    logic [id_w_lp-1:0]     order_head;
    logic [id_w_lp-1:0]     rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, gnt, arb_gnt, arb_idx;
    logic                   lock_q, lock_d, error_q, error_d;
    logic                   arb_found, cmd_fire, mem_resp_fire;

    for (genvar p = 0; p < num_ports_p; p++) begin : g_port
        bp_me_mem_mux_fifo #(.width_p(msg_width_p), .els_p(2)) cmd_buf (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .data_i   (cmd_i[p*msg_width_p +: msg_width_p]),
            .v_i      (cmd_v_i[p]),
            .ready_o  (cbuf_ready[p]),
            .data_o   (cbuf_data[p]),
            .v_o      (cbuf_v[p]),
            .yumi_i   (cbuf_yumi[p])
        );

        bp_me_mem_mux_fifo #(.width_p(msg_width_p), .els_p(2)) resp_buf (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .data_i   (mem_resp_i),
            .v_i      (rbuf_push[p]),
            .ready_o  (rbuf_ready[p]),
            .data_o   (resp_o[p*msg_width_p +: msg_width_p]),
            .v_o      (resp_v_o[p]),
            .yumi_i   (resp_yumi_i[p])
        );

        assign cmd_ready_o[p] = cbuf_ready[p] & reset_n_i;
        assign eligible[p]    = cbuf_v[p] & (cnt_q[p] < max_cnt_lp) & order_ready;
        assign cbuf_yumi[p]   = cmd_fire & (gnt == id_w_lp'(p));
        assign cnt_inc[p]     = cbuf_yumi[p];
        assign cnt_dec[p]     = resp_yumi_i[p] & resp_v_o[p];
        assign rbuf_push[p]   = mem_resp_fire & order_v & (order_head == id_w_lp'(p));
    end

    bp_me_mem_mux_fifo #(.width_p(id_w_lp), .els_p(order_fifo_els_p)) order_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .data_i   (gnt),
        .v_i      (cmd_fire),
        .ready_o  (order_ready),
        .data_o   (order_head),
        .v_o      (order_v),
        .yumi_i   (order_pop)
    );

    always_comb begin
        arb_found = 1'b0;
        arb_gnt   = '0;
        arb_idx   = '0;
        for (int i = 0; i < num_ports_p; i++) begin
            arb_idx = id_w_lp'((int'(rr_ptr_q) + i) % num_ports_p);
            if (!arb_found && eligible[arb_idx]) begin
                arb_found = 1'b1;
                arb_gnt   = arb_idx;
            end
        end
    end

    // A raised request keeps its grant until memory takes it.
    assign gnt         = lock_q ? gnt_q : arb_gnt;
    assign mem_cmd_v_o = lock_q | arb_found;
    assign mem_cmd_o   = cbuf_data[gnt];
    assign cmd_fire    = mem_cmd_v_o & mem_cmd_yumi_i;

    // With nothing outstanding, any response is drained and dropped.
    assign mem_resp_ready_o = reset_n_i & (order_v ? rbuf_ready[order_head] : mem_resp_v_i);
    assign mem_resp_fire    = mem_resp_v_i & mem_resp_ready_o;
    assign order_pop        = mem_resp_fire & order_v;
    assign error_o          = error_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt;
        lock_d   = mem_cmd_v_o & ~mem_cmd_yumi_i;
        error_d  = error_q | (mem_resp_fire & ~order_v);
        if (cmd_fire) begin
            rr_ptr_d = (gnt == last_port_lp) ? '0 : gnt + id_w_lp'(1);
        end
        for (int p = 0; p < num_ports_p; p++) begin
            cnt_d[p] = cnt_q[p];
            if (cnt_inc[p] && !cnt_dec[p]) begin
                cnt_d[p] = cnt_q[p] + cnt_w_lp'(1);
            end else if (cnt_dec[p] && !cnt_inc[p]) begin
                cnt_d[p] = cnt_q[p] - cnt_w_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            lock_q   <= 1'b0;
            error_q  <= 1'b0;
            for (int p = 0; p < num_ports_p; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            lock_q   <= lock_d;
            error_q  <= error_d;
            for (int p = 0; p < num_ports_p; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

endmodule

// File: tb/tb_bp_me_mem_port_mux.sv
// Scoreboard bench for bp_me_mem_port_mux: directed vectors push expectations,
// a negedge monitor pops and compares whenever a handshake completes.
module tb_bp_me_mem_port_mux;
    import bp_me_mem_port_mux_pkg::*;

    localparam int N = 2;
    localparam int W = $bits(bp_cce_mem_msg_s);
    typedef logic [W-1:0] msg_t;

    logic             clk_i = 1'b0;
    logic             reset_n_i = 1'b1;
    logic [N*W-1:0]   cmd_i = '0;
    logic [N-1:0]     cmd_v_i = '0;
    logic [N-1:0]     cmd_ready_o;
    logic [N*W-1:0]   resp_o;
    logic [N-1:0]     resp_v_o;
    logic [N-1:0]     resp_yumi_i = '0;
    logic [W-1:0]     mem_cmd_o;
    logic             mem_cmd_v_o;
    logic             mem_cmd_yumi_i = 1'b0;
    logic [W-1:0]     mem_resp_i = '0;
    logic             mem_resp_v_i = 1'b0;
    logic             mem_resp_ready_o;
    logic             error_o;

    bp_me_mem_port_mux #(
        .num_ports_p(N), .msg_width_p(W), .max_outstanding_p(4), .order_fifo_els_p(8)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
        .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
        .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
        .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
        .error_o(error_o)
    );

    initial forever #5 clk_i = ~clk_i;

    msg_t src_q [N][$];
    msg_t exp_resp_q [N][$];
    msg_t exp_mem_q [$];
    msg_t mem_pend_q [$];
    logic       mem_yumi_en = 1'b0;
    logic       mem_resp_en = 1'b0;
    logic [N-1:0] cli_yumi_en = '0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_acc = -1;
    int first_xfer = -1;
    int last_xfer = -1;

    function automatic msg_t mkcmd(input int tag);
        bp_cce_mem_msg_s m;
        m.msg_type = e_mem_msg_wr;
        m.addr     = 28'(tag << 6);
        m.data     = 32'hA5A5_0000 | 32'(tag);
        return m;
    endfunction

    function automatic msg_t mkresp(input int tag);
        bp_cce_mem_msg_s m;
        m.msg_type = e_mem_msg_rd;
        m.addr     = 28'(tag << 6);
        m.data     = 32'h5A5A_0000 | 32'(tag);
        return m;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic send(input int p, input int tag, input bit expect_issue);
        src_q[p].push_back(mkcmd(tag));
        if (expect_issue) exp_mem_q.push_back(mkcmd(tag));
    endtask

    task automatic mem_reply(input int p, input int tag);
        mem_pend_q.push_back(mkresp(tag));
        exp_resp_q[p].push_back(mkresp(tag));
    endtask

    task automatic wait_mem_drained(input string name, input int budget);
        for (int i = 0; i < budget && exp_mem_q.size() != 0; i++) tick(1);
        check(name, W'(exp_mem_q.size()), '0);
    endtask

    task automatic wait_resp_drained(input string name, input int budget);
        for (int i = 0; i < budget && (exp_resp_q[0].size() + exp_resp_q[1].size()) != 0; i++) tick(1);
        check(name, W'(exp_resp_q[0].size() + exp_resp_q[1].size()), '0);
    endtask

    task automatic do_reset(input string name);
        reset_n_i = 1'b0;
        #1;
        check({name, "_cmd_ready"}, W'(cmd_ready_o), '0);
        check({name, "_resp_v"}, W'(resp_v_o), '0);
        check({name, "_resp_data"}, resp_o[W-1:0] | resp_o[2*W-1:W], '0);
        check({name, "_mem_cmd_v"}, W'(mem_cmd_v_o), '0);
        check({name, "_mem_cmd"}, mem_cmd_o, '0);
        check({name, "_mem_resp_ready"}, W'(mem_resp_ready_o), '0);
        check({name, "_error"}, W'(error_o), '0);
        for (int p = 0; p < N; p++) begin
            src_q[p].delete();
            exp_resp_q[p].delete();
        end
        exp_mem_q.delete();
        mem_pend_q.delete();
        mem_yumi_en = 1'b0;
        mem_resp_en = 1'b0;
        cli_yumi_en = '0;
        tick(2);
        reset_n_i = 1'b1;
        tick(1);
    endtask

    // Input driver: updates one time unit after each rising edge.
    initial forever begin
        @(posedge clk_i);
        #1;
        cyc++;
        for (int p = 0; p < N; p++) begin
            cmd_v_i[p] = (src_q[p].size() != 0);
            cmd_i[p*W +: W] = (src_q[p].size() != 0) ? src_q[p][0] : '0;
            resp_yumi_i[p] = cli_yumi_en[p] & resp_v_o[p];
        end
        mem_cmd_yumi_i = mem_yumi_en & mem_cmd_v_o;
        mem_resp_v_i = mem_resp_en && (mem_pend_q.size() != 0);
        mem_resp_i = (mem_pend_q.size() != 0) ? mem_pend_q[0] : '0;
    end

    // Monitor: handshakes seen here complete on the next rising edge.
    initial forever begin
        @(negedge clk_i);
        if (reset_n_i) begin
            for (int p = 0; p < N; p++) begin
                if (cmd_v_i[p] && cmd_ready_o[p]) begin
                    if (first_acc < 0) first_acc = cyc;
                    void'(src_q[p].pop_front());
                end
            end
            if (mem_cmd_v_o && mem_cmd_yumi_i) begin
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
                if (exp_mem_q.size() == 0) check("mem_cmd_unexpected", mem_cmd_o, '1);
                else check("mem_cmd", mem_cmd_o, exp_mem_q.pop_front());
            end
            if (mem_resp_v_i && mem_resp_ready_o) void'(mem_pend_q.pop_front());
            for (int p = 0; p < N; p++) begin
                if (resp_v_o[p] && resp_yumi_i[p]) begin
                    if (exp_resp_q[p].size() == 0)
                        check($sformatf("resp_p%0d_unexpected", p), resp_o[p*W +: W], '1);
                    else
                        check($sformatf("resp_p%0d", p), resp_o[p*W +: W], exp_resp_q[p].pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        do_reset("rst0");
        check("idle_cmd_ready", W'(cmd_ready_o), W'(2'b11));

        // Both ports saturated: alternating grants, one command per cycle.
        first_acc = -1; first_xfer = -1; last_xfer = -1;
        mem_yumi_en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            send(0, 'h10 + s, 1'b1);
            send(1, 'h20 + s, 1'b0);
        end
        for (int s = 0; s < 4; s++) begin
            exp_mem_q.delete(2 * s + 1 < exp_mem_q.size() ? 2 * s + 1 : exp_mem_q.size());
        end
        exp_mem_q.delete();
        for (int s = 0; s < 4; s++) begin
            exp_mem_q.push_back(mkcmd('h10 + s));
            exp_mem_q.push_back(mkcmd('h20 + s));
        end
        wait_mem_drained("t1_alternate_drain", 40);
        check("t1_first_latency", W'(first_xfer - first_acc), W'(1));
        check("t1_burst_span", W'(last_xfer - first_xfer), W'(7));
        for (int s = 0; s < 4; s++) begin
            mem_reply(0, 'h10 + s);
            mem_reply(1, 'h20 + s);
        end
        mem_resp_en = 1'b1;
        cli_yumi_en = 2'b11;
        wait_resp_drained("t1_resp_drain", 60);
        check("t1_no_error", W'(error_o), '0);

        // Outstanding limit: fifth command waits for a consumed response.
        do_reset("rst1");
        mem_yumi_en = 1'b1;
        for (int s = 0; s < 5; s++) send(0, 'h30 + s, 1'b1);
        tick(20);
        check("t2_held_count", W'(exp_mem_q.size()), W'(1));
        check("t2_mem_cmd_v_held", W'(mem_cmd_v_o), '0);
        check("t2_fifth_buffered", W'(src_q[0].size()), '0);
        mem_reply(0, 'h30);
        mem_resp_en = 1'b1;
        cli_yumi_en = 2'b01;
        wait_mem_drained("t2_fifth_issued", 20);
        for (int s = 1; s < 5; s++) mem_reply(0, 'h30 + s);
        wait_resp_drained("t2_resp_drain", 60);

        // Interleaved issue and routing with client backpressure on port 1.
        do_reset("rst2");
        mem_yumi_en = 1'b1;
        cli_yumi_en = 2'b01;
        send(1, 'h41, 1'b1); wait_mem_drained("t3_issue_a", 20);
        send(0, 'h42, 1'b1); wait_mem_drained("t3_issue_b", 20);
        send(1, 'h43, 1'b1); wait_mem_drained("t3_issue_c", 20);
        send(1, 'h44, 1'b1); wait_mem_drained("t3_issue_d", 20);
        mem_reply(1, 'hA1);
        mem_reply(0, 'hB2);
        mem_reply(1, 'hC3);
        mem_reply(1, 'hD4);
        mem_resp_en = 1'b1;
        tick(10);
        check("t3_resp_ready_low", W'(mem_resp_ready_o), '0);
        check("t3_pend_held", W'(mem_pend_q.size()), W'(1));
        check("t3_resp_v1", W'(resp_v_o[1]), W'(1));
        check("t3_p0_delivered", W'(exp_resp_q[0].size()), '0);
        cli_yumi_en = 2'b11;
        wait_resp_drained("t3_resp_drain", 30);
        check("t3_pend_empty", W'(mem_pend_q.size()), '0);
        check("t3_no_error", W'(error_o), '0);

        // Orphan response: drained, not delivered, sticky error.
        do_reset("rst3");
        mem_pend_q.push_back(mkresp('hEE));
        mem_resp_en = 1'b1;
        tick(4);
        check("t4_drained", W'(mem_pend_q.size()), '0);
        check("t4_no_resp_v", W'(resp_v_o), '0);
        check("t4_error_set", W'(error_o), W'(1));
        tick(6);
        check("t4_error_sticky", W'(error_o), W'(1));

        // Reset with three in flight and a request on the memory port.
        do_reset("rst4");
        mem_yumi_en = 1'b1;
        for (int s = 0; s < 3; s++) send(0, 'h50 + s, 1'b1);
        wait_mem_drained("t5_three_issued", 20);
        mem_yumi_en = 1'b0;
        send(1, 'h60, 1'b0);
        for (int i = 0; i < 10 && !mem_cmd_v_o; i++) tick(1);
        check("t5_v_before_reset", W'(mem_cmd_v_o), W'(1));
        do_reset("rst5");
        mem_yumi_en = 1'b1;
        for (int s = 1; s < 5; s++) send(0, 'h50 + s, 1'b0);
        send(1, 'h61, 1'b0);
        exp_mem_q.push_back(mkcmd('h51));
        exp_mem_q.push_back(mkcmd('h61));
        exp_mem_q.push_back(mkcmd('h52));
        exp_mem_q.push_back(mkcmd('h53));
        exp_mem_q.push_back(mkcmd('h54));
        wait_mem_drained("t5_post_reset_issue", 30);
        check("t5_no_error", W'(error_o), '0);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
